// File: rtl/exp_add_arbiter_pkg.sv
// Shared FPU exponent-path types: adder width, requester source tag and the
// result FIFO entry layout used by the shared exponent adder arbiter.
package exp_add_arbiter_pkg;

  localparam int EXP_W      = 6;
  localparam int FIFO_DEPTH = 2;

  typedef enum logic {
    SRC_MUL  = 1'b0,
    SRC_NORM = 1'b1
  } src_t;

  typedef struct packed {
    logic [EXP_W-1:0] sum;
    src_t             src;
  } fifo_entry_t;

endpackage

// File: rtl/exp_add_arbiter_if.sv
// Handshake bundle for the shared exponent adder: two requester ports and the
// tagged result port. The arbiter sits on the slave side.
interface exp_add_arbiter_if;
  import exp_add_arbiter_pkg::*;

  logic             req0_valid;
  logic             req0_ready;
  logic [EXP_W-1:0] req0_a;
  logic [EXP_W-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [EXP_W-1:0] req1_a;
  logic [EXP_W-1:0] req1_b;

  logic             out_valid;
  logic             out_ready;
  logic [EXP_W-1:0] out_sum;
  src_t             out_src;
  logic             busy;

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  out_ready,
    output req0_ready, req1_ready,
    output out_valid, out_sum, out_src, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output out_ready,
    input  req0_ready, req1_ready,
    input  out_valid, out_sum, out_src, busy
  );

endinterface

// File: rtl/exp_add_arbiter_add_6_bit.sv
// 6-bit ripple-carry adder, no carry-in; the carry-out is dropped so the
// result is (a + b) mod 64.
module add_6_bit
  import exp_add_arbiter_pkg::*;
(
  input  logic [EXP_W-1:0] a_i,
  input  logic [EXP_W-1:0] b_i,
  output logic [EXP_W-1:0] sum_o
);

  always_comb begin
    logic carry;
    carry = 1'b0;
    sum_o = '0;
    for (int i = 0; i < EXP_W; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
  end

endmodule

// File: rtl/exp_add_arbiter.sv
// Round-robin arbiter sharing one exponent adder between the multiplier and
// normalizer paths, with a 2-entry source-tagged result FIFO.
module exp_add_arbiter
  import exp_add_arbiter_pkg::*;
#(
  parameter int W     = EXP_W,
  parameter int DEPTH = FIFO_DEPTH
) (
  input logic              clk,
  input logic              rst,
  exp_add_arbiter_if.slave bus
);

  localparam logic [1:0] DEPTH_C = 2'(DEPTH);

  logic [1:0]  count_q, count_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        rr_q, rr_d;
  fifo_entry_t mem_q [DEPTH];

  logic        space;
  logic        grant0, grant1;
  logic        push, pop;
  src_t        push_src;
  logic [W-1:0] op_a, op_b, add_sum;
  fifo_entry_t push_entry;

  // Grant depends only on registered count, so out_ready never reaches the readys.
  always_comb begin
    space  = count_q < DEPTH_C;
    grant0 = bus.req0_valid && (!bus.req1_valid || !rr_q);
    grant1 = bus.req1_valid && (!bus.req0_valid ||  rr_q);
  end

  assign bus.req0_ready = grant0 && space && !rst;
  assign bus.req1_ready = grant1 && space && !rst;

  assign push     = (bus.req0_valid && bus.req0_ready) ||
                    (bus.req1_valid && bus.req1_ready);
  assign pop      = (count_q != 2'd0) && bus.out_ready;
  assign push_src = grant1 ? SRC_NORM : SRC_MUL;
  assign op_a     = grant1 ? bus.req1_a : bus.req0_a;
  assign op_b     = grant1 ? bus.req1_b : bus.req0_b;

  add_6_bit u_add (
    .a_i   (op_a),
    .b_i   (op_b),
    .sum_o (add_sum)
  );

  assign push_entry = '{sum: add_sum, src: push_src};

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    rr_d     = rr_q;
    if (push) begin
      wr_ptr_d = ~wr_ptr_q;
      // Point at whichever requester was not served this time.
      rr_d     = (push_src == SRC_MUL);
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      rr_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rr_q     <= rr_d;
      if (push) begin
        mem_q[wr_ptr_q] <= push_entry;
      end
    end
  end

  assign bus.out_valid = count_q != 2'd0;
  assign bus.busy      = count_q != 2'd0;
  assign bus.out_sum   = mem_q[rd_ptr_q].sum;
  assign bus.out_src   = mem_q[rd_ptr_q].src;

endmodule

// File: tb/tb_exp_add_arbiter.sv
// Directed bench for exp_add_arbiter: vector table of single transactions plus
// contention, backpressure and mid-operation reset sequences.
module tb_exp_add_arbiter;
  import exp_add_arbiter_pkg::*;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;

  exp_add_arbiter_if bus ();

  exp_add_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v0;
    logic [5:0] a0;
    logic [5:0] b0;
    logic       v1;
    logic [5:0] a1;
    logic [5:0] b1;
    logic       r0;
    logic       r1;
    logic       ov;
    logic [5:0] sum;
    logic       src;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input int act, input int req);
    n_total++;
    if (act !== req) begin
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0;
    bus.req0_a     = '0;
    bus.req0_b     = '0;
    bus.req1_valid = 1'b0;
    bus.req1_a     = '0;
    bus.req1_b     = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst     = 1'b1;
    idle_inputs();
    bus.out_ready = 1'b0;

    //            v0  a0     b0     v1  a1     b1     r0  r1  ov  sum    src
    vecs[0] = '{1'b1, 6'd20, 6'd15, 1'b0, 6'd0,  6'd0,  1'b1, 1'b0, 1'b1, 6'd35, 1'b0};
    vecs[1] = '{1'b0, 6'd0,  6'd0,  1'b1, 6'd63, 6'd1,  1'b0, 1'b1, 1'b1, 6'd0,  1'b1};
    vecs[2] = '{1'b1, 6'd40, 6'd40, 1'b0, 6'd0,  6'd0,  1'b1, 1'b0, 1'b1, 6'd16, 1'b0};
    vecs[3] = '{1'b1, 6'd5,  6'd5,  1'b1, 6'd7,  6'd8,  1'b0, 1'b1, 1'b1, 6'd15, 1'b1};
    vecs[4] = '{1'b1, 6'd30, 6'd33, 1'b1, 6'd1,  6'd1,  1'b1, 1'b0, 1'b1, 6'd63, 1'b0};
    vecs[5] = '{1'b0, 6'd0,  6'd0,  1'b1, 6'd32, 6'd32, 1'b0, 1'b1, 1'b1, 6'd0,  1'b1};
    vecs[6] = '{1'b0, 6'd9,  6'd9,  1'b0, 6'd9,  6'd9,  1'b0, 1'b0, 1'b0, 6'd0,  1'b0};

    tick();
    tick();
    chk("reset_ready0", bus.req0_ready, 0);
    rst = 1'b0;
    #1;
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_out_sum", bus.out_sum, 0);
    chk("reset_out_src", bus.out_src, 0);
    chk("reset_busy", bus.busy, 0);

    // Single transactions from an empty FIFO
    for (int i = 0; i < 7; i++) begin
      bus.out_ready  = 1'b1;
      bus.req0_valid = vecs[i].v0;
      bus.req0_a     = vecs[i].a0;
      bus.req0_b     = vecs[i].b0;
      bus.req1_valid = vecs[i].v1;
      bus.req1_a     = vecs[i].a1;
      bus.req1_b     = vecs[i].b1;
      #1;
      chk($sformatf("vec%0d_ready0", i), bus.req0_ready, vecs[i].r0);
      chk($sformatf("vec%0d_ready1", i), bus.req1_ready, vecs[i].r1);
      tick();
      idle_inputs();
      #1;
      chk($sformatf("vec%0d_out_valid", i), bus.out_valid, vecs[i].ov);
      if (vecs[i].ov) begin
        chk($sformatf("vec%0d_out_sum", i), bus.out_sum, vecs[i].sum);
        chk($sformatf("vec%0d_out_src", i), bus.out_src, vecs[i].src);
      end
      tick();
      chk($sformatf("vec%0d_busy_after", i), bus.busy, 0);
    end

    // Contention with sustained draining: strict alternation, no bubbles
    do_reset();
    begin
      int idx0;
      int idx1;
      logic [5:0] exp_sum [6];
      logic       exp_src [6];
      idx0 = 0;
      idx1 = 0;
      exp_sum[0] = 6'd1;  exp_src[0] = 1'b0;
      exp_sum[1] = 6'd10; exp_src[1] = 1'b1;
      exp_sum[2] = 6'd2;  exp_src[2] = 1'b0;
      exp_sum[3] = 6'd20; exp_src[3] = 1'b1;
      exp_sum[4] = 6'd3;  exp_src[4] = 1'b0;
      exp_sum[5] = 6'd30; exp_src[5] = 1'b1;
      bus.out_ready = 1'b1;
      for (int c = 0; c <= 6; c++) begin
        if (c < 6) begin
          bus.req0_valid = 1'b1;
          bus.req0_a     = 6'(idx0 + 1);
          bus.req0_b     = 6'd0;
          bus.req1_valid = 1'b1;
          bus.req1_a     = 6'(10 * (idx1 + 1));
          bus.req1_b     = 6'd0;
        end else begin
          idle_inputs();
        end
        #1;
        if (c < 6) begin
          chk($sformatf("cont%0d_ready0", c), bus.req0_ready, (c % 2 == 0));
          chk($sformatf("cont%0d_ready1", c), bus.req1_ready, (c % 2 == 1));
        end
        if (c > 0) begin
          chk($sformatf("cont%0d_out_valid", c), bus.out_valid, 1);
          chk($sformatf("cont%0d_out_sum", c), bus.out_sum, exp_sum[c-1]);
          chk($sformatf("cont%0d_out_src", c), bus.out_src, exp_src[c-1]);
        end
        tick();
        if (c % 2 == 0) idx0++;
        else            idx1++;
      end
      chk("cont_busy_end", bus.busy, 0);
    end

    // Backpressure: two accepts, then stall until a pop
    do_reset();
    bus.out_ready  = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_a = 6'd1; bus.req0_b = 6'd2;
    #1;
    chk("bp_accept1", bus.req0_ready, 1);
    tick();
    bus.req0_a = 6'd3; bus.req0_b = 6'd4;
    #1;
    chk("bp_accept2", bus.req0_ready, 1);
    chk("bp_head1", bus.out_sum, 3);
    tick();
    bus.req0_a = 6'd5; bus.req0_b = 6'd6;
    #1;
    chk("bp_full_ready", bus.req0_ready, 0);
    chk("bp_full_head", bus.out_sum, 3);
    chk("bp_full_src", bus.out_src, 0);
    chk("bp_full_busy", bus.busy, 1);
    tick();
    bus.out_ready = 1'b1;
    #1;
    chk("bp_pop_no_pushthru", bus.req0_ready, 0);
    chk("bp_head_stable", bus.out_sum, 3);
    tick();
    bus.out_ready = 1'b0;
    #1;
    chk("bp_accept3", bus.req0_ready, 1);
    chk("bp_head2", bus.out_sum, 7);
    tick();
    idle_inputs();
    bus.out_ready = 1'b1;
    #1;
    chk("bp_order2", bus.out_sum, 7);
    tick();
    chk("bp_order3", bus.out_sum, 11);
    chk("bp_order3_valid", bus.out_valid, 1);
    tick();
    chk("bp_drained", bus.busy, 0);

    // Reset with a full FIFO and rr pointing at requester 1
    do_reset();
    bus.out_ready  = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_a = 6'd11; bus.req0_b = 6'd12;
    tick();
    bus.req0_a = 6'd13; bus.req0_b = 6'd14;
    tick();
    chk("rst_mid_full", bus.busy, 1);
    bus.req1_valid = 1'b1;
    bus.req1_a = 6'd2; bus.req1_b = 6'd2;
    rst = 1'b1;
    #1;
    chk("rst_mid_ready0", bus.req0_ready, 0);
    chk("rst_mid_ready1", bus.req1_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_mid_out_valid", bus.out_valid, 0);
    chk("rst_mid_out_sum", bus.out_sum, 0);
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_grant0", bus.req0_ready, 1);
    chk("rst_mid_grant1", bus.req1_ready, 0);
    tick();
    idle_inputs();
    #1;
    chk("rst_mid_first_sum", bus.out_sum, 27);
    chk("rst_mid_first_src", bus.out_src, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/exp_add_arbiter.md
# exp_add_arbiter

Shares one 6-bit adder between two FPU requesters. Requester 0 is the multiplier exponent-sum path; requester 1 is the normalizer exponent-adjust path. Arbitration is round-robin, and each requester uses a valid/ready handshake. Results are buffered in a 2-entry output FIFO tagged with the source index, so the single adder instance can serve both paths at up to one operation per cycle.

## Interface
- `W`, 6: operand/result width; fixed to the shared adder width, not to be overridden.
- `DEPTH`, 2: output FIFO depth; fixed at 2.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has an operand pair.
- `req0_ready`  out  1  requester 0 pair accepted this cycle.
- `req0_a`, `req0_b`  in  6 each  requester 0 operands.
- `req1_valid`  in  1  requester 1 has an operand pair.
- `req1_ready`  out  1  requester 1 pair accepted this cycle.
- `req1_a`, `req1_b`  in  6 each  requester 1 operands.
- `out_valid`  out  1  FIFO head holds a result.
- `out_ready`  in  1  consumer takes head this cycle.
- `out_sum`  out  6  head result, (a+b) mod 64.
- `out_src`  out  1  head source index (0/1).
- `busy`  out  1  FIFO non-empty.

## Operation
- Transfer on an input port: `reqX_valid && reqX_ready`. Transfer on the output port: `out_valid && out_ready`.
- `space` = count < 2, using the registered count. No push-through when full, even if a pop occurs the same cycle.
- Grant logic, combinational:
  - Only one valid: that requester is granted.
  - Both valid: the requester indexed by `rr_ptr` is granted.
  - `reqX_ready` = granted_X && space.
  - At most one ready is high per cycle.
- `rr_ptr`, 1 bit: on each accepted request it becomes the index of the requester NOT served. It is unchanged on idle cycles and when a push is blocked.
- Arithmetic:
  - The granted operands are muxed into one adder instance.
  - The sum is the low 6 bits; carry-out is discarded (63+1 gives 0).
  - No carry-in.
- Push: the accepted sum and source are written at the tail on the accepting edge.
- FIFO:
  - count ∈ {0,1,2}.
  - Push only: count+1. Pop only: count−1. Push and pop together (count must be 1): count unchanged, head and tail advance.
  - Pointers are 1 bit and wrap modulo 2.
- `out_valid` = count≠0. `busy` = count≠0.
- `out_sum`/`out_src` come directly from the head entry, which is registered.
- Output stability: while `out_valid && !out_ready`, `out_sum` and `out_src` hold stable.
- Requester handshake: requesters must hold operands stable while valid and not ready. The block does not check this.
- Reset, sync, at an edge with `rst`=1:
  - count=0, pointers=0, `rr_ptr`=0, all FIFO entries=0.
  - `out_valid`=0, `out_sum`=0, `out_src`=0, `busy`=0.
  - Any in-flight or pending request is dropped. While `rst`=1, `reqX_ready`=0.

## Timing
- Latency: an operand accepted at edge T appears at the FIFO head with `out_valid` high in cycle T+1, when the FIFO was empty before T.
- Throughput: one op per cycle sustained when `out_ready` is held high, with count toggling between 0 and 1.
- Backpressure: with `out_ready` low, at most two accepts occur. Both `reqX_ready` are low from the cycle after the second accept until the first pop edge. The first accept after that is the edge following the pop.
- Fairness: with both requesters continuously valid, grants alternate strictly. The first grant after reset goes to requester 0.
- No combinational path from `out_ready` to `reqX_ready`. There is a combinational path from `reqX_valid` to the other port's ready, through the grant logic.

## Structure
- Shared FPU package holds:
  - the `EXP_W`=6 constant;
  - a `src_t` 1-bit typedef with values `SRC_MUL`=0 and `SRC_NORM`=1;
  - the FIFO entry struct {sum, src}.
- One sub-module: the existing 6-bit ripple adder `add_6_bit`, instantiated once on the muxed operands.
- The FIFO is inline; no separate FIFO module.

## Test plan
- Single request: after reset, req0 a=20, b=15 for one cycle. `req0_ready`=1. Next cycle `out_valid`=1, `out_sum`=35, `out_src`=0. With `out_ready`=1, `busy` drops the following cycle.
- Wrap: req1 a=63, b=1 → `out_sum`=0, `out_src`=1. Also a=40, b=40 → 16.
- Contention: both valid every cycle with `out_ready`=1, req0 sums 1,2,3… and req1 sums 10,20,30… Output order is src 0,1,0,1 with sums 1,10,2,20. Each ready is high on alternate cycles.
- Backpressure: `out_ready`=0, req0 valid with three pairs. The first two are accepted on consecutive cycles, then `req0_ready`=0 and the head stays stable. Raise `out_ready` for one cycle → the third is accepted on the next edge, and the output order is preserved.
- Simultaneous push/pop at count=1: the stream continues with count remaining 1 and no bubbles or duplicates.
- Reset mid-operation: FIFO holds 2 entries and `rr_ptr`=1, then assert `rst` for one cycle. Afterwards `out_valid`=0, `out_sum`=0, and with both requesters valid the first grant goes to requester 0.
